// File: rtl/mem_ctrl.sv
// mem_ctrl: load/store front end for the MCU data memory.
// Turns byte/half/word core requests into word-wide RAM accesses.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_*           core request (valid/ready, byte address, size,
//                   signedness, right-aligned store data)
//   resp_*          one-cycle completion pulse, load data, error flag
//   mem_*           single-port RAM (word address, 1-cycle read)
//
// Optional feature: define MEM_CTRL_ALIGN_CHECK_EN to reject
// misaligned half/word accesses with resp_err and no RAM access.

module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_RESP
    } state_t;

    state_t      state;
    logic        we_q;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [15:0] wdata_q;
    logic        wr_en_q;
    logic        err_q;

    logic        req_sub;
    logic        is_byte;
    logic        is_half;
    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [31:0] merged;

    // A write already launched is killed by reset in the same cycle.
    assign mem_wr_en = wr_en_q & ~rst;
    assign resp_err  = err_q;

    assign req_sub = (req_size == 2'b00) || (req_size == 2'b01);
    assign is_byte = (size_q == 2'b00);
    assign is_half = (size_q == 2'b01);

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    logic misalign;
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

    // Lane extraction and sign/zero extension of the loaded word.
    always_comb begin
        rd_shift  = mem_rdata >> {lane_q, 3'b000};
        rd_byte   = rd_shift[7:0];
        rd_half   = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = mem_rdata;
        unique case (1'b1)
            is_byte: load_data = {{24{sgn_q & rd_byte[7]}}, rd_byte};
            is_half: load_data = {{16{sgn_q & rd_half[15]}}, rd_half};
            default: load_data = mem_rdata;
        endcase
    end

    // Sub-word store: overwrite only the addressed lane(s).
    always_comb begin
        merged = mem_rdata;
        unique case (1'b1)
            is_byte: merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            is_half: begin
                if (lane_q[1]) merged[31:16] = wdata_q;
                else           merged[15:0]  = wdata_q;
            end
            default: merged = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            err_q      <= 1'b0;
            mem_rd_en  <= 1'b0;
            wr_en_q    <= 1'b0;
            mem_addr   <= 16'h0;
            mem_wdata  <= 32'h0;
            we_q       <= 1'b0;
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            sgn_q      <= 1'b0;
            wdata_q    <= 16'h0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        lane_q    <= req_addr[1:0];
                        size_q    <= req_size;
                        sgn_q     <= req_signed;
                        wdata_q   <= req_wdata[15:0];
                        mem_addr  <= {2'b00, req_addr[15:2]};
`ifdef MEM_CTRL_ALIGN_CHECK_EN
                        if (misalign) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'h0;
                            err_q      <= 1'b1;
                        end else
`endif
                        if (!req_we || req_sub) begin
                            state     <= S_RD;
                            mem_rd_en <= 1'b1;
                        end else begin
                            state     <= S_WR;
                            wr_en_q   <= 1'b1;
                            mem_wdata <= req_wdata;
                        end
                    end else begin
                        // Also raises ready the first cycle after reset.
                        req_ready <= 1'b1;
                    end
                end
                S_RD: begin
                    mem_rd_en <= 1'b0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (we_q) begin
                        mem_wdata <= merged;
                        wr_en_q   <= 1'b1;
                        state     <= S_WR;
                    end else begin
                        resp_rdata <= load_data;
                        resp_valid <= 1'b1;
                        err_q      <= 1'b0;
                        state      <= S_RESP;
                    end
                end
                S_WR: begin
                    wr_en_q    <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'h0;
                    err_q      <= 1'b0;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Load/store front end for the MCU data memory. It sits directly upstream of the single-port 32-bit block RAM. It accepts byte, halfword and word requests from the core on a byte-addressed valid/ready interface and turns them into word-wide RAM reads and writes. Sub-word stores use read-modify-write. Load results are lane-extracted and sign- or zero-extended.

## Interface
Parameters:
- none

Ports:
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: core presents a request.
- `req_ready` output 1: block can accept; a request transfers on `req_valid && req_ready` at a rising edge.
- `req_we` input 1: 1 = store, 0 = load.
- `req_addr` input 16: byte address.
- `req_size` input 2: 00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- `req_signed` input 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` output 1: one-cycle completion pulse for every accepted request; no backpressure.
- `resp_rdata` output 32: formatted load data, valid with `resp_valid`; 0 for stores.
- `resp_err` output 1: misaligned access flag, valid with `resp_valid`.
- `mem_rd_en` output 1: RAM read enable.
- `mem_wr_en` output 1: RAM write enable.
- `mem_addr` output 16: RAM word address = {2'b00, addr[15:2]}.
- `mem_wdata` output 32: RAM write data.
- `mem_rdata` input 32: RAM read data, valid the cycle after `mem_rd_en`.

## Operation
- Request fields are latched on acceptance and held until the response.
- Lanes are little-endian:
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (bits [15:0] or [31:16]).
- States and transitions:
  - IDLE: `req_ready`=1. On accept:
    - misaligned (with check enabled) → RESP.
    - load → RD.
    - word store → WR.
    - sub-word store → RD.
  - RD: `mem_rd_en`=1 → WAIT.
  - WAIT:
    - Load: extract lane from `mem_rdata`, extend, register into the result → RESP.
    - Sub-word store: merge `req_wdata` lanes into `mem_rdata`, register the merged word → WR.
  - WR: `mem_wr_en`=1; `mem_wdata` = full `req_wdata` (word) or the merged word → RESP.
  - RESP: `resp_valid`=1 → IDLE.
- Only the addressed bytes change on sub-word stores; all other bytes keep their prior value.
- Extension:
  - Byte: bit 7 is replicated into [31:8].
  - Half: bit 15 is replicated into [31:16].
  - Zero-extension clears those bits.
  - Word ignores `req_signed`.
- `mem_rd_en` and `mem_wr_en` are never both high. Each is high for exactly one cycle per access.

## Timing
- Cycle 0 is the accept edge. `resp_valid` is high in the cycle after:
  - Load: 3 edges.
  - Word store: 2 edges.
  - Sub-word store: 4 edges.
  - Misaligned error: 1 edge.
- Maximum throughput is one request per latency+1 cycles. `req_ready`=0 outside IDLE.
- `resp_rdata` and `resp_err` hold their value until the next RESP. `resp_valid` is high only in RESP.
- Reset values:
  - state = IDLE.
  - `req_ready`, `resp_valid`, `resp_rdata`, `resp_err`, `mem_rd_en`, `mem_wr_en`, `mem_addr`, `mem_wdata` = 0.
  - `req_ready` rises in the first cycle after `rst` deasserts.
- Reset mid-operation:
  - The in-flight request is dropped, with no response.
  - If `rst` is high in a WR cycle, the write is suppressed (`mem_wr_en` is gated by `!rst`).
- `req_valid` while not ready: ignored; the core must hold the request.

## Configuration
- `MEM_CTRL_ALIGN_CHECK_EN` defined:
  - A half with addr[0]=1, or a word with addr[1:0]≠0, issues no RAM access.
  - The block goes IDLE→RESP with `resp_err`=1 and `resp_rdata`=0.
- `MEM_CTRL_ALIGN_CHECK_EN` undefined:
  - Half uses addr[1] and ignores addr[0]; word ignores addr[1:0].
  - `resp_err` is constant 0.

## Test plan
- Word store 0xDEADBEEF to 0x0010, then word load from 0x0010 → `mem_addr`=0x0004 on both accesses; load `resp_rdata`=0xDEADBEEF; `resp_valid` 2 and 3 edges after the respective accepts.
- Word 0x11223344 at 0x0020; byte store 0xAA to 0x0022 → RAM word becomes 0x11AA3344; exactly one `mem_rd_en` pulse, then one `mem_wr_en` pulse; response 4 edges after accept.
- Word 0x80FF7F01 at 0x0030:
  - Signed byte load from 0x0032 → 0xFFFFFFFF.
  - Unsigned byte load from 0x0032 → 0x000000FF.
  - Signed half load from 0x0030 → 0x00007F01.
  - Signed half load from 0x0032 → 0xFFFF80FF.
- With the macro defined: word load from 0x0041 → `resp_err`=1 and `resp_rdata`=0 one edge after accept, no RAM enables. Without the macro: the same request reads word 0x0010 with `resp_err`=0.
- `rst` asserted for one cycle during WR of a word store → `mem_wr_en` stays 0; no `resp_valid`; RAM word unchanged; `req_ready`=1 the cycle after `rst` falls.
- Back-to-back: `req_valid` held high with 3 queued loads → accepts spaced exactly 4 cycles apart; `req_ready` low between accepts.
